// File: rtl/rounding_unit_fraction_rounder.sv
// Two-stage fraction rounder: truncates IN_WIDTH to OUT_WIDTH bits using one of five IEEE-style modes.
// Define ROUNDING_UNIT_INEXACT_FLAG_EN to produce the inexact flag; otherwise inexact is tied low.
module rounding_unit_fraction_rounder #(
  parameter int IN_WIDTH  = 49,
  parameter int OUT_WIDTH = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           rounding_mode,
  input  logic                 sign,
  input  logic [IN_WIDTH-1:0]  normalized_fraction,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] rounded_fraction,
  output logic                 carry_out,
  output logic                 inexact
);

  localparam int STICKY_W = IN_WIDTH - OUT_WIDTH - 1;

  function automatic logic round_inc(input logic [2:0] mode, input logic sgn,
                                     input logic grd, input logic stk, input logic lsb);
    case (mode)
      3'b001:  return 1'b0;
      3'b010:  return sgn & (grd | stk);
      3'b011:  return ~sgn & (grd | stk);
      3'b100:  return grd;
      default: return grd & (stk | lsb);
    endcase
  endfunction

  logic [OUT_WIDTH-1:0] kept_p0;
  logic                 guard_p0;
  logic                 sticky_p0;
  logic                 inc_p0;

  logic                 vld_p1;
  logic [OUT_WIDTH-1:0] kept_p1;
  logic                 inc_p1;
  logic [OUT_WIDTH:0]   sum_p1;

  logic                 adv_p2;

  // stage 0: split operand into kept / guard / sticky and decide increment
  assign kept_p0   = normalized_fraction[IN_WIDTH-1 -: OUT_WIDTH];
  assign guard_p0  = normalized_fraction[STICKY_W];
  assign sticky_p0 = |normalized_fraction[STICKY_W-1:0];
  assign inc_p0    = round_inc(rounding_mode, sign, guard_p0, sticky_p0, kept_p0[0]);

  // Output stage advances when empty or being drained; input stage follows it.
  assign adv_p2   = ~out_valid | out_ready;
  assign in_ready = ~vld_p1 | adv_p2;

  // stage 1: registered kept bits and increment decision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      kept_p1 <= kept_p0;
      inc_p1  <= inc_p0;
    end
  end

  assign sum_p1 = {1'b0, kept_p1} + (OUT_WIDTH+1)'(inc_p1);

  // stage 2: registered sum and carry, cleared on reset so outputs read zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid        <= 1'b0;
      rounded_fraction <= '0;
      carry_out        <= 1'b0;
    end else if (adv_p2) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        rounded_fraction <= sum_p1[OUT_WIDTH-1:0];
        carry_out        <= sum_p1[OUT_WIDTH];
      end
    end
  end

`ifdef ROUNDING_UNIT_INEXACT_FLAG_EN
  logic inexact_p1;

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      inexact_p1 <= guard_p0 | sticky_p0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inexact <= 1'b0;
    end else if (adv_p2 && vld_p1) begin
      inexact <= inexact_p1;
    end
  end
`else
  assign inexact = 1'b0;
`endif

endmodule

// File: doc/rounding_unit_fraction_rounder.md
ROUNDING_UNIT_FRACTION_ROUNDER -- requirements
Module: rounding_unit_fraction_rounder

Interface
REQ-001 Parameter IN_WIDTH, default 49, input fraction width; [xx.xxx...] format, 2 integer bits.
REQ-002 Parameter OUT_WIDTH, default 25, kept fraction width; 2 integer bits; IN_WIDTH >= OUT_WIDTH+2 SHALL hold.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  input operand valid.
REQ-006 in_ready  output  1  block can accept an operand this cycle.
REQ-007 rounding_mode  input  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE.
REQ-008 sign  input  1  operand sign; used only by RDN/RUP.
REQ-009 normalized_fraction  input  IN_WIDTH  unrounded fraction.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 rounded_fraction  output  OUT_WIDTH  rounded fraction, same binary point as input top bits.
REQ-013 carry_out  output  1  increment overflowed OUT_WIDTH bits.
REQ-014 inexact  output  1  discarded bits were nonzero.

Function
REQ-015 kept = normalized_fraction[IN_WIDTH-1 -: OUT_WIDTH]; guard = next lower bit; sticky = OR of all remaining lower bits.
REQ-016 Increment decision: RNE guard&(sticky|kept[0]); RTZ 0; RDN sign&(guard|sticky); RUP ~sign&(guard|sticky); RMM guard.
REQ-017 Result = kept + increment computed OUT_WIDTH+1 wide; rounded_fraction = low OUT_WIDTH bits, carry_out = MSB (all-ones kept wraps to zero).
REQ-018 Two-stage pipeline: stage 1 registers kept, increment decision, inexact; stage 2 registers sum and carry_out.
REQ-019 Transfer occurs on valid&ready at a rising edge; latency from input transfer to out_valid is exactly 2 cycles when unstalled.
REQ-020 Throughput one operand per cycle while out_ready=1.
REQ-021 Each stage advances when its downstream is empty or draining; in_ready = ~stage1_valid | stage2 advancing.
REQ-022 out_valid=1 with out_ready=0: rounded_fraction, carry_out, inexact, out_valid SHALL hold stable.
REQ-023 Simultaneous input accept and output drain in one cycle: no operand lost or duplicated; order preserved.
REQ-024 in_valid=0 with in_ready=1: stage 1 becomes empty; no spurious output.
REQ-025 Outputs SHALL be registered; no combinational path from normalized_fraction to outputs.

Reset
REQ-026 reset=1 asynchronously clears both stage valid bits: out_valid=0, rounded_fraction=0, carry_out=0, inexact=0.
REQ-027 in_ready=1 during and after reset; in-flight operands at reset are discarded, never emitted.
REQ-028 First transfer after reset deassertion accepted on the first rising edge with reset=0.

Configuration
REQ-029 Macro ROUNDING_UNIT_INEXACT_FLAG_EN defined: inexact = guard|sticky, pipelined alongside its operand.
REQ-030 Macro undefined: inexact tied to 0, no inexact pipeline registers; all other behaviour identical.

Verification (defaults, inexact macro defined)
REQ-031 RNE tie, lsb 1: normalized_fraction=0x0800001800000 -> 2 cycles later rounded_fraction=0x0800002, carry_out=0, inexact=1.
REQ-032 RNE tie, lsb 0: 0x0800000800000 -> 0x0800000, inexact=1; RTZ 0x0800001FFFFFF -> 0x0800001, inexact=1.
REQ-033 Directed modes: 0x0800000000001 sign=0 RUP -> 0x0800001; RDN -> 0x0800000; RDN sign=1 -> 0x0800001; exact 0x0800000000000 any mode -> 0x0800000, inexact=0.
REQ-034 Overflow: 0x1FFFFFF800000 RNE -> rounded_fraction=0x0000000, carry_out=1.
REQ-035 Backpressure: 3 back-to-back operands, out_ready=0 for 4 cycles -> outputs hold first result, in_ready=0 once both stages full, release drains all 3 in order with no loss.
REQ-036 Reset mid-stream: reset pulse with 2 operands in flight -> out_valid=0 immediately, neither emitted, next accepted operand appears 2 cycles after acceptance.
